// File: rtl/fxp_pkg.sv
// fxp_pkg
// Shared definitions for the fixed-point streaming datapath.
//   state_e     : accumulator stream state (ACCUM collecting, HOLD presenting)
//   acc_width() : accumulator width that cannot overflow for max_len beats
//   sext()      : sign-extend the low w bits of a value to 64 bits
//   sat_signed(): clamp a 64-bit signed value into the signed w-bit range
// The helpers work on a 64-bit carrier so one function serves every width.
package fxp_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int acc_width(input int n, input int max_len);
    return n + $clog2(max_len);
  endfunction

  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    // Park the sign bit at bit 63, then arithmetic-shift back down.
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// fxp_sat_add
// Combinational signed adder that clips to the W-bit range instead of wrapping.
//   a_i, b_i : signed W-bit operands
//   sum_o    : a_i + b_i, clipped to [-2^(W-1), 2^(W-1)-1]
//   ovf_o    : the true sum did not fit and sum_o was clipped
module fxp_sat_add #(
  parameter int W = 14
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);

  logic [W:0] wide;

  // One guard bit catches overflow: the top two bits disagree exactly when
  // the result left the W-bit range, and the guard bit gives its direction.
  always_comb begin
    wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    ovf_o = wide[W] ^ wide[W-1];
    if (!ovf_o) begin
      sum_o = wide[W-1:0];
    end else if (wide[W]) begin
      sum_o = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum_o = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fxp_acc_stream.sv
// fxp_acc_stream
// Streaming packet accumulator for Qm.F products: sums every beat of a packet
// in a wide saturating accumulator and emits one clamped N-bit result per
// packet in the same Q format.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last : product stream, one packet per result
//   out_valid/out_ready/out_data  : result stream, one beat per packet
//   out_sat                       : result was clipped to N bits
//   out_ovr                       : packet was longer than MAX_LEN beats
module fxp_acc_stream
  import fxp_pkg::*;
#(
  parameter int N       = 8,
  parameter int F       = 7,
  parameter int MAX_LEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat,
  output logic         out_ovr
);

  localparam int ACC_W = acc_width(N, MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N-1:0]            data_q, data_d;
  logic                    sat_q, sat_d;
  logic                    ovr_q, ovr_d;

  logic                    accept;
  logic signed [63:0]      inExt;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] accSum;
  logic                    addOvf;
  logic signed [63:0]      sumWide;
  logic signed [63:0]      clampWide;
  logic [CNT_W-1:0]        cntInc;

  // A new packet may start in the same cycle the held result is taken, so
  // HOLD only blocks input while the downstream is stalling.
  assign in_ready  = (state_q == ACCUM) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign out_ovr   = ovr_q;

  // The addend is forced to zero unless a beat is really accepted, so
  // undriven data on idle cycles never reaches the accumulator.
  always_comb begin
    inExt  = sext(64'(in_data), N);
    addend = accept ? inExt[ACC_W-1:0] : '0;
  end

  fxp_sat_add #(
    .W(ACC_W)
  ) u_sat_add (
    .a_i  (acc_q),
    .b_i  (addend),
    .sum_o(accSum),
    .ovf_o(addOvf)
  );

  // Output clamp of the would-be accumulator value. A clipped accumulator
  // also counts as saturation, which matters when ACC_W has no headroom.
  always_comb begin
    sumWide   = 64'(accSum);
    clampWide = sat_signed(sumWide, N);
    cntInc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  end

  // acc and cnt are zero whenever a packet starts (reset or just after a
  // result is registered), so a beat accepted in HOLD naturally opens the
  // next packet from 0.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    if ((state_q == HOLD) && out_ready) begin
      state_d = ACCUM;
    end
    if (accept) begin
      if (in_last) begin
        data_d  = clampWide[N-1:0];
        sat_d   = (clampWide != sumWide) || addOvf;
        ovr_d   = (cntInc > CNT_MAX);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = HOLD;
      end else begin
        acc_d = accSum;
        cnt_d = cntInc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  // The fractional point must lie inside the word.
  always_ff @(posedge clk) begin
    assert (F >= 0 && F < N);
  end

endmodule

// File: tb/tb_fxp_acc_stream.sv
// tb_fxp_acc_stream
// Directed and randomized stream checks of fxp_acc_stream against a packet
// level reference model (integer sums, clamping, a queue of pending results).
module tb_fxp_acc_stream;

  localparam int N       = 8;
  localparam int F       = 7;
  localparam int MAX_LEN = 4;
  localparam int ACC_W   = N + $clog2(MAX_LEN);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sat;
  logic         out_ovr;

  typedef struct {
    logic [N-1:0] data;
    logic         sat;
    logic         ovr;
  } result_t;

  result_t expQ[$];
  int      modelSum;
  int      modelBeats;
  int      compareCount  = 0;
  int      mismatchCount = 0;
  int      readyMode     = 2;

  bit      monReady;
  int      monBeat;
  int      monClip;
  result_t monRes;

  fxp_acc_stream #(
    .N(N),
    .F(F),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_ovr  (out_ovr)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  always begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampTo(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model, evaluated mid-cycle: the model alone decides whether a
  // result is pending and whether a beat is taken at the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      monReady = (expQ.size() == 0) || out_ready;
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(monReady));
      if (expQ.size() != 0) begin
        checkOutput("out_data", 32'(out_data), 32'(expQ[0].data));
        checkOutput("out_sat", 32'(out_sat), 32'(expQ[0].sat));
        checkOutput("out_ovr", 32'(out_ovr), 32'(expQ[0].ovr));
        if (out_ready) expQ.delete(0);
      end
      if (in_valid && monReady) begin
        monBeat    = $signed(in_data);
        modelSum   = clampTo(modelSum + monBeat, ACC_W);
        modelBeats = modelBeats + 1;
        if (in_last) begin
          monClip     = clampTo(modelSum, N);
          monRes.data = monClip[N-1:0];
          monRes.sat  = (monClip != modelSum);
          monRes.ovr  = (modelBeats > MAX_LEN);
          expQ.push_back(monRes);
          modelSum   = 0;
          modelBeats = 0;
        end
      end
    end
  end

  // Present one beat from posedge+1 and keep it until the DUT takes it.
  task automatic applyStimulus(input logic [N-1:0] d, input logic last);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 'x;
    if (!taken) checkOutput("beat_timeout", 32'(taken), 32'd1);
  endtask

  // With the downstream stalled, the result must show up right after the last beat.
  task automatic expectHeld(input string tag, input logic [N-1:0] d, input logic s, input logic o);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(d));
    checkOutput({tag, "_sat"}, 32'(out_sat), 32'(s));
    checkOutput({tag, "_ovr"}, 32'(out_ovr), 32'(o));
    #2;
  endtask

  task automatic releaseResult();
    readyMode = 0;
    repeat (2) @(posedge clk);
    readyMode = 2;
    #1;
  endtask

  task automatic enterReset();
    rst_n = 1'b0;
    expQ.delete();
    modelSum   = 0;
    modelBeats = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_sat"}, 32'(out_sat), 32'd0);
    checkOutput({tag, "_ovr"}, 32'(out_ovr), 32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int len;
    logic [N-1:0] d;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    modelSum   = 0;
    modelBeats = 0;
    enterReset();
    #3;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 0.25 + 0.25 = 0.5
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h20, 1'b1);
    expectHeld("half", 8'h40, 1'b0, 1'b0);
    releaseResult();

    // +2.0 and -2.0 clip to the rails
    repeat (3) applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h40, 1'b1);
    expectHeld("pos_sat", 8'h7F, 1'b1, 1'b0);
    releaseResult();
    applyStimulus(8'h80, 1'b0);
    applyStimulus(8'h80, 1'b1);
    expectHeld("neg_sat", 8'h80, 1'b1, 1'b0);
    releaseResult();

    // Mixed signs, then a 3-cycle stall with a beat waiting at the input
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h08, 1'b1);
    expectHeld("mixed", 8'h08, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_data", 32'(out_data), 32'h08);
    end
    #2;
    in_valid = 1'b0;
    releaseResult();

    // Back-to-back: single-beat packet accepted in the result handshake cycle
    applyStimulus(8'h20, 1'b1);
    expectHeld("single", 8'h20, 1'b0, 1'b0);
    readyMode = 0;
    in_valid  = 1'b1;
    in_data   = 8'h7F;
    in_last   = 1'b1;
    repeat (2) @(posedge clk);
    readyMode = 2;
    #1;
    in_valid = 1'b0;
    expectHeld("b2b", 8'h7F, 1'b0, 1'b0);
    releaseResult();

    // Length overrun: 6 beats against MAX_LEN = 4
    repeat (5) applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b1);
    expectHeld("overrun", 8'h06, 1'b0, 1'b1);
    releaseResult();

    // Reset while a result is held
    applyStimulus(8'h33, 1'b1);
    expectHeld("pre_rst", 8'h33, 1'b0, 1'b0);
    enterReset();
    #1;
    checkResetOutputs("rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-packet must drop the partial sum
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h30, 1'b0);
    #2;
    enterReset();
    #1;
    checkResetOutputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h05, 1'b1);
    expectHeld("post_rst", 8'h05, 1'b0, 1'b0);
    releaseResult();

    // Random packets with random backpressure and idle gaps
    readyMode = 1;
    for (int p = 0; p < 250; p++) begin
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 3))
          0:       d = N'($urandom_range(0, 16)) - N'(8);
          1:       d = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
          default: d = N'($urandom);
        endcase
        applyStimulus(d, 1'(b == len - 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    readyMode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
